// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage feeding the instruction decode bank. Owns the program counter,
// issues single-outstanding req/ack reads to instruction memory, buffers the
// returned words in a small prefetch FIFO and presents the FIFO head to decode
// with a valid/stall handshake. A branch redirect flushes the FIFO and any
// read already on the bus is completed and its data discarded.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-low reset
//   stall           decode not ready; head entry held while high
//   branch_valid    redirect request this cycle
//   branch_target   redirect address
//   mem_req         read request to instruction memory (registered)
//   mem_addr        read address, held stable until mem_ack (registered)
//   mem_ack         memory returns mem_rdata this cycle (may be same cycle)
//   mem_rdata       instruction word, valid with mem_ack
//   instr_valid     instruction_out / pc_count hold a valid entry
//   instruction_out FIFO head instruction
//   pc_count        address the head instruction was fetched from
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [PC_W-1:0]   branch_target,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction_out,
  output logic [PC_W-1:0]   pc_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   fetch_pc;
  logic [DATA_W-1:0] fifo_instr [DEPTH];
  logic [PC_W-1:0]   fifo_pc    [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  logic              flush;
  logic              pop;
  logic              push;
  logic [CW-1:0]     free;
  logic [CW-1:0]     next_count;
  logic [AW-1:0]     next_rd;
  logic              head_is_new;

  // A branch flushes the FIFO and wins over a pop in the same cycle. Data
  // is only pushed for a live (non-abandoned) request that is not being
  // redirected this cycle.
  always_comb begin
    flush       = branch_valid;
    pop         = instr_valid && !stall && !branch_valid;
    push        = (state == REQ) && mem_ack && !branch_valid;
    free        = CW'(DEPTH) - count + CW'(pop);
    next_count  = count - CW'(pop) + CW'(push);
    next_rd     = rd_ptr + AW'(pop);
    // After the pop the FIFO is empty, so a pushed word becomes the head
    // directly and must be bypassed into the output registers.
    head_is_new = ((count - CW'(pop)) == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      fetch_pc        <= RESET_PC;
      count           <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      mem_req         <= 1'b0;
      mem_addr        <= RESET_PC;
      instr_valid     <= 1'b0;
      instruction_out <= '0;
      pc_count        <= '0;
    end else begin
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          fifo_instr[wr_ptr] <= mem_rdata;
          fifo_pc[wr_ptr]    <= fetch_pc;
          wr_ptr             <= wr_ptr + AW'(1);
        end
        rd_ptr <= next_rd;
        count  <= next_count;
      end

      // Output registers track the FIFO head as it will be after this edge;
      // data is left untouched when the FIFO goes empty.
      if (flush || (next_count == '0)) begin
        instr_valid <= 1'b0;
      end else begin
        instr_valid <= 1'b1;
        if (head_is_new) begin
          instruction_out <= mem_rdata;
          pc_count        <= fetch_pc;
        end else begin
          instruction_out <= fifo_instr[next_rd];
          pc_count        <= fifo_pc[next_rd];
        end
      end

      case (state)
        IDLE: begin
          if (branch_valid) begin
            fetch_pc <= branch_target;
            mem_addr <= branch_target;
            mem_req  <= 1'b1;
            state    <= REQ;
          end else if (free != '0) begin
            mem_addr <= fetch_pc;
            mem_req  <= 1'b1;
            state    <= REQ;
          end
        end

        REQ: begin
          if (mem_ack && !branch_valid) begin
            fetch_pc <= fetch_pc + PC_W'(1);
            mem_addr <= fetch_pc + PC_W'(1);
            // Only keep requesting if a slot is still guaranteed after
            // this push, so the FIFO can never overflow.
            if (free <= CW'(1)) begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end else if (mem_ack && branch_valid) begin
            fetch_pc <= branch_target;
            mem_addr <= branch_target;
          end else if (branch_valid) begin
            // The request already on the bus must complete at its original
            // address; its data is thrown away in DROP.
            fetch_pc <= branch_target;
            state    <= DROP;
          end
        end

        DROP: begin
          if (mem_ack) begin
            fetch_pc <= branch_valid ? branch_target : fetch_pc;
            mem_addr <= branch_valid ? branch_target : fetch_pc;
            state    <= REQ;
          end else if (branch_valid) begin
            fetch_pc <= branch_target;
          end
        end

        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. A behavioural memory returns
// 32'hA000_0000 + address; ack_en gates whether it answers (zero-wait when
// set, stalled when clear). Each step advances one clock edge and inspects
// outputs 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_valid;
  logic [7:0]  branch_target;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instruction_out;
  logic [7:0]  pc_count;
  logic        ack_en;

  int checks;
  int errors;

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .branch_valid    (branch_valid),
    .branch_target   (branch_target),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .instr_valid     (instr_valid),
    .instruction_out (instruction_out),
    .pc_count        (pc_count)
  );

  // Memory answers in the same cycle as the request whenever ack_en is set.
  assign mem_ack   = mem_req && ack_en;
  assign mem_rdata = 32'hA000_0000 + 32'(mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic stl,
                               input logic bv, input logic [7:0] bt,
                               input logic ae);
    reset         = rst;
    stall         = stl;
    branch_valid  = bv;
    branch_target = bt;
    ack_en        = ae;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Checks valid, pc and instruction of a head entry fetched from the model.
  task automatic checkHead(input string tag, input logic [7:0] pc);
    checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd1);
    checkOutput({tag, "_pc"}, 32'(pc_count), 32'(pc));
    checkOutput({tag, "_instr"}, instruction_out, 32'hA000_0000 + 32'(pc));
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    tick();
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_pc", 32'(pc_count), 32'd0);
    checkOutput("rst_instr", instruction_out, 32'd0);

    // Zero-wait streaming: request in cycle 1, first instruction in cycle 2
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("c1_req", 32'(mem_req), 32'd1);
    checkOutput("c1_addr", 32'(mem_addr), 32'd0);
    checkOutput("c1_valid", 32'(instr_valid), 32'd0);
    tick();
    checkHead("stream0", 8'h00);
    tick();
    checkHead("stream1", 8'h01);
    tick();
    checkHead("stream2", 8'h02);
    tick();
    checkHead("stream3", 8'h03);

    // Stall for 5 cycles at pc 3: FIFO fills with pc 3,4 then requests stop
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkHead("stall_hold", 8'h03);
      checkOutput("stall_req", 32'(mem_req), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkHead("release4", 8'h04);
    checkOutput("release_req", 32'(mem_req), 32'd1);
    checkOutput("release_addr", 32'(mem_addr), 32'd5);
    tick();
    checkHead("release5", 8'h05);
    tick();
    checkHead("release6", 8'h06);

    // Branch together with ack and a pop: acked word (pc 7) is dropped
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h20, 1'b1);
    tick();
    checkOutput("brack_valid", 32'(instr_valid), 32'd0);
    checkOutput("brack_req", 32'(mem_req), 32'd1);
    checkOutput("brack_addr", 32'(mem_addr), 32'h20);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkHead("brack_first", 8'h20);

    // Late memory: branch to 0x40 while waiting on the read of 0x21
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("late_w1_addr", 32'(mem_addr), 32'h21);
    checkOutput("late_w1_valid", 32'(instr_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h40, 1'b0);
    tick();
    checkOutput("late_w2_addr", 32'(mem_addr), 32'h21);
    checkOutput("late_w2_req", 32'(mem_req), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("late_w3_addr", 32'(mem_addr), 32'h21);
    checkOutput("late_w3_valid", 32'(instr_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("late_drop_valid", 32'(instr_valid), 32'd0);
    checkOutput("late_new_addr", 32'(mem_addr), 32'h40);
    checkOutput("late_new_req", 32'(mem_req), 32'd1);
    tick();
    checkHead("late_first", 8'h40);

    // PC wrap: FE, FF, 00, 01
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFE, 1'b1);
    tick();
    checkOutput("wrap_addr", 32'(mem_addr), 32'hFE);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkHead("wrapFE", 8'hFE);
    tick();
    checkHead("wrapFF", 8'hFF);
    tick();
    checkHead("wrap00", 8'h00);
    tick();
    checkHead("wrap01", 8'h01);

    // Reset while REQ is waiting with one entry in the FIFO
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checkHead("pre_rst_head", 8'h01);
    checkOutput("pre_rst_req", 32'(mem_req), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("midrst_valid", 32'(instr_valid), 32'd0);
    checkOutput("midrst_req", 32'(mem_req), 32'd0);
    checkOutput("midrst_addr", 32'(mem_addr), 32'd0);
    checkOutput("midrst_pc", 32'(pc_count), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("restart_req", 32'(mem_req), 32'd1);
    checkOutput("restart_addr", 32'(mem_addr), 32'd0);
    checkOutput("restart_valid", 32'(instr_valid), 32'd0);
    tick();
    checkHead("restart0", 8'h00);
    tick();
    checkHead("restart1", 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
